// File: rtl/hamming_enc_arbiter.sv
// Round-robin front end that lets two requesters share one Hamming(15,11) encoder.
// One word is in flight at a time; the code word leaves on a valid/ready port with its source tag.

module encod (
    input  logic [10:0] data_i,
    output logic [14:0] code_o
);
    logic p1, p2, p4, p8;

    // Data fills code positions 3,5,6,7,9..15; parity bit 2^k covers every position with bit k set.
    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6] ^ data_i[8] ^ data_i[10];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6] ^ data_i[9] ^ data_i[10];
    assign p4 = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7] ^ data_i[8] ^ data_i[9] ^ data_i[10];
    assign p8 = ^data_i[10:4];

    assign code_o = {data_i[10:4], p8, data_i[3:1], p4, data_i[0], p2, p1};
endmodule

module hamming_enc_arbiter #(
    parameter int ENC_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [10:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [10:0]      req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [14:0]      out_code,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int LAT_W = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ENC_LAT - 1);

    typedef enum logic [1:0] {IDLE, ENC, HOLD} state_e;

    state_e             state_q;
    logic [10:0]        din_q;
    logic               src_q;
    logic               last_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic               out_valid_q;
    logic [14:0]        out_code_q;
    logic               out_src_q;
    logic [CNT_W-1:0]   cnt0_q;
    logic [CNT_W-1:0]   cnt1_q;

    logic               grant_vld;
    logic               grant_sel;
    logic [14:0]        enc_code;

    encod u_encod (
        .data_i (din_q),
        .code_o (enc_code)
    );

    // On a tie the requester that was not served last wins; a lone requester always wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    end

    assign req0_ready = (state_q == IDLE) && grant_vld && !grant_sel;
    assign req1_ready = (state_q == IDLE) && grant_vld &&  grant_sel;

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != IDLE);
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

    // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignment,
    // so a same-cycle handshake or consumption is simply overridden by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            din_q       <= '0;
            src_q       <= 1'b0;
            last_q      <= 1'b1;
            lat_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_src_q   <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        din_q     <= req1_ready ? req1_data : req0_data;
                        src_q     <= req1_ready;
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= ENC;
                    end
                end
                ENC: begin
                    if (lat_cnt_q == '0) begin
                        out_code_q  <= enc_code;
                        out_src_q   <= src_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (src_q) cnt1_q <= cnt1_q + CNT_W'(1);
                        else       cnt0_q <= cnt0_q + CNT_W'(1);
                        last_q      <= src_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed bench for hamming_enc_arbiter: one instance with ENC_LAT=1/CNT_W=8, one with ENC_LAT=3/CNT_W=2.
// Expected code words are hand-computed Hamming(15,11) constants.

module tb_hamming_enc_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic        v0;
        logic [10:0] d0;
        logic        v1;
        logic [10:0] d1;
        logic        src;
        logic [14:0] code;
        int          stall;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        r0v  [2];
    logic        r1v  [2];
    logic        ordy [2];
    logic [10:0] r0d  [2];
    logic [10:0] r1d  [2];

    logic        a_r0r, a_r1r, a_ov, a_src, a_busy;
    logic [14:0] a_code;
    logic [7:0]  a_c0, a_c1;
    logic        b_r0r, b_r1r, b_ov, b_src, b_busy;
    logic [14:0] b_code;
    logic [1:0]  b_c0, b_c1;

    logic        r0r  [2];
    logic        r1r  [2];
    logic        ov   [2];
    logic        osrc [2];
    logic        bsy  [2];
    logic [14:0] ocode[2];
    logic [7:0]  c0   [2];
    logic [7:0]  c1   [2];

    always_comb begin
        r0r[0] = a_r0r;  r0r[1] = b_r0r;
        r1r[0] = a_r1r;  r1r[1] = b_r1r;
        ov[0]  = a_ov;   ov[1]  = b_ov;
        osrc[0] = a_src; osrc[1] = b_src;
        bsy[0] = a_busy; bsy[1] = b_busy;
        ocode[0] = a_code; ocode[1] = b_code;
        c0[0] = a_c0;    c0[1] = {6'd0, b_c0};
        c1[0] = a_c1;    c1[1] = {6'd0, b_c1};
    end

    hamming_enc_arbiter #(.ENC_LAT(LAT_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst[0]),
        .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(a_r0r),
        .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(a_r1r),
        .out_valid(a_ov), .out_code(a_code), .out_src(a_src), .out_ready(ordy[0]),
        .busy(a_busy), .cnt0(a_c0), .cnt1(a_c1)
    );

    hamming_enc_arbiter #(.ENC_LAT(LAT_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst[1]),
        .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(b_r0r),
        .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(b_r1r),
        .out_valid(b_ov), .out_code(b_code), .out_src(b_src), .out_ready(ordy[1]),
        .busy(b_busy), .cnt0(b_c0), .cnt1(b_c1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: DUT event did not occur within the cycle budget", name);
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic do_reset(input int u, input string tag);
        @(negedge clk);
        rst[u] = 1'b1;
        r0v[u] = 1'b0; r1v[u] = 1'b0; r0d[u] = '0; r1d[u] = '0; ordy[u] = 1'b0;
        @(negedge clk);
        rst[u] = 1'b0;
        check({tag, " rst out_valid"}, 32'(ov[u]), 0);
        check({tag, " rst out_code"},  32'(ocode[u]), 0);
        check({tag, " rst out_src"},   32'(osrc[u]), 0);
        check({tag, " rst busy"},      32'(bsy[u]), 0);
        check({tag, " rst counters"},  32'({c0[u], c1[u]}), 0);
        check({tag, " rst readys"},    32'({r0r[u], r1r[u]}), 0);
    endtask

    task automatic wait_ready(input int u, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (r0r[u] || r1r[u]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int u, output bit ok, output int lat, output bit bad);
        ok = 1'b0; lat = 0; bad = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (r0r[u] || r1r[u] || !bsy[u]) bad = 1'b1;
            if (ov[u]) begin
                ok = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    // One complete word: arbitration, settle latency, optional stall, consumption.
    task automatic do_word(input int u, input vec_t v, input string tag);
        bit ok;
        bit bad;
        int lat;
        r0v[u] = v.v0; r0d[u] = v.d0; r1v[u] = v.v1; r1d[u] = v.d1;
        ordy[u] = (v.stall == 0);
        wait_ready(u, ok);
        if (!ok) begin
            fail({tag, " grant_timeout"});
            return;
        end
        check({tag, " single_ready"}, 32'(r0r[u] & r1r[u]), 0);
        check({tag, " grant"},        32'(r1r[u]), 32'(v.src));
        check({tag, " idle_busy"},    32'(bsy[u]), 0);
        wait_valid(u, ok, lat, bad);
        if (!ok) begin
            fail({tag, " out_valid_timeout"});
            return;
        end
        check({tag, " latency"},      32'(lat), 32'(lat_of(u) + 1));
        check({tag, " ready_low_busy_high"}, 32'(bad), 0);
        check({tag, " out_code"},     32'(ocode[u]), 32'(v.code));
        check({tag, " out_src"},      32'(osrc[u]), 32'(v.src));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check({tag, " stall_stable"},
                  32'({ov[u], osrc[u], ocode[u], r0r[u], r1r[u]}),
                  32'({1'b1, v.src, v.code, 2'b00}));
        end
        ordy[u] = 1'b1;
        @(negedge clk);
        check({tag, " consumed"}, 32'({ov[u], bsy[u]}), 0);
    endtask

    vec_t      vecs[10];
    vec_t      wb;
    logic [7:0] e0, e1;
    bit         ok;
    bit         bad;
    int         lat;
    logic [10:0] b_data[5];
    logic [14:0] b_codes[5];
    logic [1:0]  b_cseq[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 11'h787, 1'b1, 11'h001, 1'b0, 15'h7834, 0};
        vecs[1] = '{1'b1, 11'h787, 1'b1, 11'h001, 1'b1, 15'h0007, 0};
        vecs[2] = '{1'b1, 11'h787, 1'b1, 11'h001, 1'b0, 15'h7834, 0};
        vecs[3] = '{1'b1, 11'h787, 1'b1, 11'h001, 1'b1, 15'h0007, 0};
        vecs[4] = '{1'b0, 11'h000, 1'b1, 11'h7FF, 1'b1, 15'h7FFF, 0};
        vecs[5] = '{1'b0, 11'h000, 1'b1, 11'h400, 1'b1, 15'h408B, 0};
        vecs[6] = '{1'b0, 11'h000, 1'b1, 11'h010, 1'b1, 15'h0181, 0};
        vecs[7] = '{1'b1, 11'h555, 1'b0, 11'h000, 1'b0, 15'h552D, 3};
        vecs[8] = '{1'b1, 11'h7FF, 1'b1, 11'h555, 1'b1, 15'h552D, 0};
        vecs[9] = '{1'b1, 11'h400, 1'b1, 11'h000, 1'b0, 15'h408B, 0};

        b_data  = '{11'h787, 11'h001, 11'h7FF, 11'h400, 11'h010};
        b_codes = '{15'h7834, 15'h0007, 15'h7FFF, 15'h408B, 15'h0181};
        b_cseq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; r0v[u] = 1'b0; r1v[u] = 1'b0;
            r0d[u] = '0; r1d[u] = '0; ordy[u] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Single zero word from requester 0.
        do_reset(0, "a_first");
        wb = '{1'b1, 11'h000, 1'b0, 11'h000, 1'b0, 15'h0000, 0};
        do_word(0, wb, "a_zero");
        check("a_zero cnt0", 32'(c0[0]), 1);

        // Table: alternation, lone requesters, stall, further ties.
        do_reset(0, "a_table");
        e0 = 8'd0; e1 = 8'd0;
        for (int i = 0; i < 10; i++) begin
            do_word(0, vecs[i], $sformatf("a_vec%0d", i));
            if (vecs[i].src) e1 = e1 + 8'd1;
            else             e0 = e0 + 8'd1;
            check($sformatf("a_vec%0d cnt0", i), 32'(c0[0]), 32'(e0));
            check($sformatf("a_vec%0d cnt1", i), 32'(c1[0]), 32'(e1));
        end

        // Reset while the word is in ENC.
        do_reset(0, "a_pre_enc");
        r0v[0] = 1'b1; r0d[0] = 11'h555; ordy[0] = 1'b0;
        wait_ready(0, ok);
        if (!ok) fail("a_enc_rst grant_timeout");
        @(negedge clk);
        check("a_enc_rst busy_in_enc", 32'(bsy[0]), 1);
        rst[0] = 1'b1; r0v[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        check("a_enc_rst out_valid", 32'(ov[0]), 0);
        check("a_enc_rst busy", 32'(bsy[0]), 0);
        check("a_enc_rst counters", 32'({c0[0], c1[0]}), 0);
        repeat (3) @(negedge clk);
        check("a_enc_rst not_delivered", 32'(ov[0]), 0);

        // Reset in HOLD on the same edge as out_ready: reset wins, nothing counted.
        r1v[0] = 1'b1; r1d[0] = 11'h7FF; ordy[0] = 1'b0;
        wait_ready(0, ok);
        if (!ok) fail("a_hold_rst grant_timeout");
        wait_valid(0, ok, lat, bad);
        if (!ok) fail("a_hold_rst out_valid_timeout");
        rst[0] = 1'b1; ordy[0] = 1'b1; r1v[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        check("a_hold_rst out_valid", 32'(ov[0]), 0);
        check("a_hold_rst out_code", 32'(ocode[0]), 0);
        check("a_hold_rst counters", 32'({c0[0], c1[0]}), 0);
        @(negedge clk);
        check("a_idle_out_ready no_effect", 32'({ov[0], bsy[0]}), 0);

        // First tie after reset goes to requester 0.
        wb = '{1'b1, 11'h001, 1'b1, 11'h010, 1'b0, 15'h0007, 0};
        do_word(0, wb, "a_post_rst_tie");
        check("a_post_rst cnt0", 32'(c0[0]), 1);
        check("a_post_rst cnt1", 32'(c1[0]), 0);

        // ENC_LAT=3, CNT_W=2: long settle, 5-cycle stall, counter wrap.
        do_reset(1, "b");
        for (int i = 0; i < 5; i++) begin
            wb = '{1'b1, b_data[i], 1'b0, 11'h000, 1'b0, b_codes[i], (i == 0) ? 5 : 0};
            do_word(1, wb, $sformatf("b_word%0d", i));
            check($sformatf("b_word%0d cnt0", i), 32'(c0[1]), 32'(b_cseq[i]));
        end
        check("b cnt1", 32'(c1[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
